// File: rtl/seq_scan_arbiter.sv
// Two-requester round-robin front end that time-shares one serial pattern matcher.
// Each granted word is scanned MSB-first, and the match count is returned with a done pulse.
module seq_scan_arbiter #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [WORD_W-1:0] word0,
  input  logic              req1,
  input  logic [WORD_W-1:0] word1,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              cfg_overlap,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int VC_W = $clog2(PAT_W + 1);
  localparam int IX_W = $clog2(WORD_W + 1);
  localparam logic [VC_W-1:0] PAT_VC   = VC_W'(PAT_W);
  localparam logic [IX_W-1:0] LAST_IDX = IX_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state, w_state_n;
  logic [WORD_W-1:0]  r_word, w_word_n;
  logic [PAT_W-1:0]   r_pat, w_pat_n;
  logic               r_ovl, w_ovl_n;
  logic [PAT_W-1:0]   r_win, w_win_n;
  logic [VC_W-1:0]    r_vcnt, w_vcnt_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [IX_W-1:0]    r_idx, w_idx_n;
  logic               r_id, w_id_n;
  logic               r_rr, w_rr_n;
  logic               r_gnt0, w_gnt0_n;
  logic               r_gnt1, w_gnt1_n;
  logic               r_done, w_done_n;
  logic               r_done_id, w_done_id_n;
  logic [CNT_W-1:0]   r_match_cnt, w_match_cnt_n;

  logic               w_bit;
  logic [PAT_W:0]     w_win_ext;
  logic [PAT_W-1:0]   w_win_shift;
  logic [VC_W-1:0]    w_vcnt_inc;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) return c;
    return c + CNT_W'(1);
  endfunction

  // Valid-bit count stops at PAT_W: beyond that the window is simply full.
  function automatic logic [VC_W-1:0] vcnt_inc(input logic [VC_W-1:0] v);
    if (v >= PAT_VC) return PAT_VC;
    return v + VC_W'(1);
  endfunction

  assign w_bit       = r_word[WORD_W-1];
  assign w_win_ext   = {r_win, w_bit};
  assign w_win_shift = w_win_ext[PAT_W-1:0];
  assign w_vcnt_inc  = vcnt_inc(r_vcnt);
  assign w_match     = (w_win_shift == r_pat) && (w_vcnt_inc == PAT_VC);
  assign w_cnt_upd   = w_match ? sat_inc(r_cnt) : r_cnt;

  always_comb begin
    w_state_n     = r_state;
    w_word_n      = r_word;
    w_pat_n       = r_pat;
    w_ovl_n       = r_ovl;
    w_win_n       = r_win;
    w_vcnt_n      = r_vcnt;
    w_cnt_n       = r_cnt;
    w_idx_n       = r_idx;
    w_id_n        = r_id;
    w_rr_n        = r_rr;
    w_gnt0_n      = 1'b0;
    w_gnt1_n      = 1'b0;
    w_done_n      = 1'b0;
    w_done_id_n   = r_done_id;
    w_match_cnt_n = r_match_cnt;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_pat_n   = cfg_pat;
          w_ovl_n   = cfg_overlap;
          w_win_n   = '0;
          w_vcnt_n  = '0;
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = S_SHIFT;
          // req0 wins unless req1 is also up and it is req1's turn.
          if (req0 && (!req1 || !r_rr)) begin
            w_word_n = word0;
            w_gnt0_n = 1'b1;
            w_id_n   = 1'b0;
            w_rr_n   = 1'b1;
          end else begin
            w_word_n = word1;
            w_gnt1_n = 1'b1;
            w_id_n   = 1'b1;
            w_rr_n   = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        w_word_n = r_word << 1;
        w_win_n  = w_win_shift;
        w_vcnt_n = (w_match && !r_ovl) ? '0 : w_vcnt_inc;
        w_cnt_n  = w_cnt_upd;
        w_idx_n  = r_idx + IX_W'(1);
        if (r_idx == LAST_IDX) begin
          w_match_cnt_n = w_cnt_upd;
          w_done_n      = 1'b1;
          w_done_id_n   = r_id;
          w_state_n     = S_DONE;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_pat       <= '0;
      r_ovl       <= 1'b0;
      r_win       <= '0;
      r_vcnt      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_id        <= 1'b0;
      r_rr        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_word      <= w_word_n;
      r_pat       <= w_pat_n;
      r_ovl       <= w_ovl_n;
      r_win       <= w_win_n;
      r_vcnt      <= w_vcnt_n;
      r_cnt       <= w_cnt_n;
      r_idx       <= w_idx_n;
      r_id        <= w_id_n;
      r_rr        <= w_rr_n;
      r_gnt0      <= w_gnt0_n;
      r_gnt1      <= w_gnt1_n;
      r_done      <= w_done_n;
      r_done_id   <= w_done_id_n;
      r_match_cnt <= w_match_cnt_n;
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter: default 8/3/4 instance plus a PAT_W=1 instance.
module tb_seq_scan_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] word0, word1;
  logic [2:0] cfg_pat;
  logic       cfg_overlap;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [3:0] match_cnt;

  logic       b_req0, b_req1;
  logic [7:0] b_word0, b_word1;
  logic [0:0] b_pat;
  logic       b_ovl;
  logic       b_gnt0, b_gnt1, b_busy, b_done, b_done_id;
  logic [3:0] b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_scan_arbiter #(.WORD_W(8), .PAT_W(3), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .word0(word0), .req1(req1), .word1(word1),
    .cfg_pat(cfg_pat), .cfg_overlap(cfg_overlap),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  seq_scan_arbiter #(.WORD_W(8), .PAT_W(1), .CNT_W(4)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .word0(b_word0), .req1(b_req1), .word1(b_word1),
    .cfg_pat(b_pat), .cfg_overlap(b_ovl),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .busy(b_busy), .done(b_done),
    .done_id(b_done_id), .match_cnt(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle cur of a scan; runs through the done cycle and the return to idle.
  task automatic finish_scan(input int cur, input logic id, input logic [3:0] cnt, input string tag);
    for (int c = cur + 1; c < 8; c++) begin
      tick();
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      chk({tag, "_nognt"}, {gnt0, gnt1}, 0);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_id"}, done_id, id);
    chk({tag, "_cnt"}, match_cnt, cnt);
    chk({tag, "_busy8"}, busy, 1);
    chk({tag, "_nognt8"}, {gnt0, gnt1}, 0);
    tick();
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_cnt_hold"}, match_cnt, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; word0 = 0; word1 = 0;
    cfg_pat = 3'b101; cfg_overlap = 1;
    b_req0 = 0; b_req1 = 0; b_word0 = 0; b_word1 = 0; b_pat = 1'b1; b_ovl = 1;
    tick(); tick();
    rst_n = 1;
    chk("rst_outs", {gnt0, gnt1, busy, done, done_id}, 0);
    chk("rst_cnt", match_cnt, 0);

    // 0xAA, pattern 101, overlapping
    word0 = 8'hAA; req0 = 1;
    tick();
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    chk("t1_busy0", busy, 1);
    req0 = 0;
    finish_scan(0, 1'b0, 4'd3, "t1");

    // same word, non-overlapping
    cfg_overlap = 0; req0 = 1;
    tick();
    chk("t2_gnt0", gnt0, 1);
    req0 = 0;
    finish_scan(0, 1'b0, 4'd2, "t2");

    // configuration is latched at grant
    cfg_overlap = 1; cfg_pat = 3'b101; word0 = 8'b1101_1011; req0 = 1;
    tick();
    chk("t4_gnt0", gnt0, 1);
    req0 = 0;
    tick();
    tick();
    cfg_pat = 3'b000;
    finish_scan(2, 1'b0, 4'd2, "t4");
    cfg_pat = 3'b111;

    // both requesters held from reset: grants alternate
    rst_n = 0;
    tick();
    rst_n = 1;
    word0 = 8'hFF; word1 = 8'h00; req0 = 1; req1 = 1;
    tick();
    chk("t3_g0_gnt0", gnt0, 1);
    chk("t3_g0_gnt1", gnt1, 0);
    finish_scan(0, 1'b0, 4'd6, "t3a");
    tick();
    chk("t3_g1_gnt1", gnt1, 1);
    chk("t3_g1_gnt0", gnt0, 0);
    finish_scan(0, 1'b1, 4'd0, "t3b");
    tick();
    chk("t3_g2_gnt0", gnt0, 1);
    chk("t3_g2_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    finish_scan(0, 1'b0, 4'd6, "t3c");

    // reset in cycle 4 of a scan aborts it
    cfg_pat = 3'b101; word0 = 8'hAA; req0 = 1;
    tick();
    chk("t5_gnt0", gnt0, 1);
    req0 = 0;
    tick(); tick(); tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t5_rst_outs", {gnt0, gnt1, busy, done, done_id}, 0);
    chk("t5_rst_cnt", match_cnt, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t5_no_done", {done, busy, gnt0, gnt1}, 0);
    end
    word1 = 8'hAA; req1 = 1;
    tick();
    chk("t5_gnt1", gnt1, 1);
    chk("t5_gnt0", gnt0, 0);
    req1 = 0;
    finish_scan(0, 1'b1, 4'd3, "t5");

    // PAT_W=1 instance: every bit of 0xFF matches
    b_word0 = 8'hFF; b_pat = 1'b1; b_ovl = 1; b_req0 = 1;
    tick();
    chk("p1_gnt0", b_gnt0, 1);
    b_req0 = 0;
    for (int c = 1; c < 8; c++) begin
      tick();
      chk("p1_nodone", b_done, 0);
    end
    tick();
    chk("p1_done", b_done, 1);
    chk("p1_id", b_done_id, 0);
    chk("p1_cnt", b_cnt, 8);
    tick();
    chk("p1_done_pulse", b_done, 0);
    chk("p1_idle", b_busy, 0);
    chk("p1_cnt_hold", b_cnt, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
